// File: rtl/dmc_pkg.sv
// Shared types and constants for the dual-model response checker.
//   state_t : checker FSM states (WARM, CHECK, PASS, FAIL)
//   ERR_W   : width of the saturating mismatch counter
//   CYC_W   : width of the compare-cycle counter and captured cycle index
package dmc_pkg;

  typedef enum logic [1:0] {
    WARM  = 2'd0,
    CHECK = 2'd1,
    PASS  = 2'd2,
    FAIL  = 2'd3
  } state_t;

  localparam int unsigned ERR_W = 16;
  localparam int unsigned CYC_W = 32;

endpackage

// File: rtl/dmc_delay_line.sv
// Enabled shift register that lines the stimulus word up with the model outputs.
// Ports:
//   clk    : clock
//   rst    : synchronous active-high reset, clears every stage to 0
//   en     : shift enable; when low the chain holds
//   i_data : word entering the chain
//   o_data : word DEPTH enabled cycles old (i_data directly when DEPTH = 0)
module dmc_delay_line #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned DEPTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_data
);

  if (DEPTH == 0) begin : g_bypass
    assign o_data = i_data;
  end else begin : g_chain
    logic [WIDTH-1:0] r_chain [DEPTH];

    always_ff @(posedge clk) begin
      if (rst) begin
        for (int i = 0; i < int'(DEPTH); i++) begin
          r_chain[i] <= '0;
        end
      end else if (en) begin
        r_chain[0] <= i_data;
        for (int i = 1; i < int'(DEPTH); i++) begin
          r_chain[i] <= r_chain[i-1];
        end
      end
    end

    assign o_data = r_chain[DEPTH-1];
  end

endmodule

// File: rtl/dual_model_checker.sv
// Clocked response checker for dual-model equivalence benches. Compares the VHDL and
// Verilog model outputs every enabled cycle after a warm-up, counts mismatches,
// captures the first failing sample and settles on a sticky PASS/FAIL verdict.
// Ports:
//   clk, rst           : clock, synchronous active-high reset
//   en                 : advance enable; low freezes counters, state and delay line
//   stim_in            : stimulus word fed to both models
//   o_vhdl, o_verilog  : model outputs under comparison
//   busy / done / pass : WARM or CHECK / PASS or FAIL / PASS only
//   err_cnt            : saturating mismatch count
//   fail_vhdl/verilog  : model outputs at the first mismatch
//   fail_stim          : aligned stimulus at the first mismatch
//   fail_cycle         : compare index (0-based after warm-up) of the first mismatch
module dual_model_checker
  import dmc_pkg::*;
#(
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned IN_W    = 4,
  parameter int unsigned LAT     = 1,
  parameter int unsigned WARMUP  = 10,
  parameter int unsigned RUN_LEN = 20000,
  parameter int unsigned MAX_ERR = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [IN_W-1:0]   stim_in,
  input  logic [DATA_W-1:0] o_vhdl,
  input  logic [DATA_W-1:0] o_verilog,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [ERR_W-1:0]  err_cnt,
  output logic [DATA_W-1:0] fail_vhdl,
  output logic [DATA_W-1:0] fail_verilog,
  output logic [IN_W-1:0]   fail_stim,
  output logic [CYC_W-1:0]  fail_cycle
);

  localparam int unsigned WARM_W = (WARMUP > 1) ? $clog2(WARMUP) : 1;
  // WARMUP = 0 still spends the single post-reset cycle in WARM.
  localparam logic [WARM_W-1:0] WARM_LAST = (WARMUP > 0) ? WARM_W'(WARMUP - 1) : '0;
  localparam logic [CYC_W-1:0]  RUN_END   = CYC_W'(RUN_LEN);
  localparam logic [ERR_W-1:0]  ERR_LIMIT = ERR_W'(MAX_ERR);

  state_t              r_state, w_state_next;
  logic [WARM_W-1:0]   r_warm_cnt, w_warm_next;
  logic [CYC_W-1:0]    r_cmp_cnt, w_cmp_next, w_cmp_inc;
  logic [ERR_W-1:0]    r_err_cnt, w_err_next, w_err_after;
  logic [DATA_W-1:0]   r_fail_vhdl, r_fail_verilog;
  logic [IN_W-1:0]     r_fail_stim;
  logic [CYC_W-1:0]    r_fail_cycle;
  logic [IN_W-1:0]     w_stim_aligned;
  logic                w_mismatch;
  logic                w_capture;

  dmc_delay_line #(
    .WIDTH (IN_W),
    .DEPTH (LAT)
  ) u_stim_delay (
    .clk    (clk),
    .rst    (rst),
    .en     (en),
    .i_data (stim_in),
    .o_data (w_stim_aligned)
  );

  // Case inequality so X/Z on either model output is flagged in simulation.
  assign w_mismatch = (o_vhdl !== o_verilog);

  assign w_cmp_inc   = r_cmp_cnt + CYC_W'(1);
  assign w_err_after = (w_mismatch && (r_err_cnt != '1)) ? r_err_cnt + ERR_W'(1) : r_err_cnt;

  always_comb begin
    w_state_next = r_state;
    w_warm_next  = r_warm_cnt;
    w_cmp_next   = r_cmp_cnt;
    w_err_next   = r_err_cnt;
    w_capture    = 1'b0;
    if (en) begin
      case (r_state)
        WARM: begin
          if (r_warm_cnt == WARM_LAST) begin
            w_state_next = CHECK;
          end else begin
            w_warm_next = r_warm_cnt + WARM_W'(1);
          end
        end
        CHECK: begin
          w_cmp_next = w_cmp_inc;
          w_err_next = w_err_after;
          w_capture  = w_mismatch && (r_err_cnt == '0);
          // Early abort wins over the end-of-run verdict on the same cycle.
          if ((MAX_ERR != 0) && (w_err_after >= ERR_LIMIT)) begin
            w_state_next = FAIL;
          end else if (w_cmp_inc == RUN_END) begin
            w_state_next = (w_err_after == '0) ? PASS : FAIL;
          end
        end
        default: begin
          w_state_next = r_state;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= WARM;
      r_warm_cnt     <= '0;
      r_cmp_cnt      <= '0;
      r_err_cnt      <= '0;
      r_fail_vhdl    <= '0;
      r_fail_verilog <= '0;
      r_fail_stim    <= '0;
      r_fail_cycle   <= '0;
    end else begin
      r_state    <= w_state_next;
      r_warm_cnt <= w_warm_next;
      r_cmp_cnt  <= w_cmp_next;
      r_err_cnt  <= w_err_next;
      if (w_capture) begin
        r_fail_vhdl    <= o_vhdl;
        r_fail_verilog <= o_verilog;
        r_fail_stim    <= w_stim_aligned;
        r_fail_cycle   <= r_cmp_cnt;
      end
    end
  end

  assign busy         = (r_state == WARM) || (r_state == CHECK);
  assign done         = (r_state == PASS) || (r_state == FAIL);
  assign pass         = (r_state == PASS);
  assign err_cnt      = r_err_cnt;
  assign fail_vhdl    = r_fail_vhdl;
  assign fail_verilog = r_fail_verilog;
  assign fail_stim    = r_fail_stim;
  assign fail_cycle   = r_fail_cycle;

endmodule

// File: tb/tb_dual_model_checker.sv
// Self-checking bench for dual_model_checker. Two instances share all inputs: index 0
// stops at the first mismatch (MAX_ERR=1), index 1 never stops early (MAX_ERR=0).
// A behavioural model tracks enabled cycles since reset and derives every output.
module tb_dual_model_checker;

  localparam int unsigned DATA_W  = 16;
  localparam int unsigned IN_W    = 4;
  localparam int unsigned LAT     = 1;
  localparam int unsigned WARMUP  = 10;
  localparam int unsigned RUN_LEN = 100;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              en  = 1'b0;
  logic [IN_W-1:0]   stim_in   = '0;
  logic [DATA_W-1:0] o_vhdl    = '0;
  logic [DATA_W-1:0] o_verilog = '0;

  logic              busy [2];
  logic              done [2];
  logic              pass [2];
  logic [15:0]       err_cnt [2];
  logic [DATA_W-1:0] fail_vhdl [2];
  logic [DATA_W-1:0] fail_verilog [2];
  logic [IN_W-1:0]   fail_stim [2];
  logic [31:0]       fail_cycle [2];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dual_model_checker #(
    .DATA_W (DATA_W), .IN_W (IN_W), .LAT (LAT),
    .WARMUP (WARMUP), .RUN_LEN (RUN_LEN), .MAX_ERR (1)
  ) u_dut_stop (
    .clk (clk), .rst (rst), .en (en), .stim_in (stim_in),
    .o_vhdl (o_vhdl), .o_verilog (o_verilog),
    .busy (busy[0]), .done (done[0]), .pass (pass[0]), .err_cnt (err_cnt[0]),
    .fail_vhdl (fail_vhdl[0]), .fail_verilog (fail_verilog[0]),
    .fail_stim (fail_stim[0]), .fail_cycle (fail_cycle[0])
  );

  dual_model_checker #(
    .DATA_W (DATA_W), .IN_W (IN_W), .LAT (LAT),
    .WARMUP (WARMUP), .RUN_LEN (RUN_LEN), .MAX_ERR (0)
  ) u_dut_run (
    .clk (clk), .rst (rst), .en (en), .stim_in (stim_in),
    .o_vhdl (o_vhdl), .o_verilog (o_verilog),
    .busy (busy[1]), .done (done[1]), .pass (pass[1]), .err_cnt (err_cnt[1]),
    .fail_vhdl (fail_vhdl[1]), .fail_verilog (fail_verilog[1]),
    .fail_stim (fail_stim[1]), .fail_cycle (fail_cycle[1])
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [31:0]       m_n [2];     // enabled cycles since reset while running
  logic [31:0]       m_err [2];
  logic              m_done [2];
  logic              m_pass [2];
  logic [DATA_W-1:0] m_fv [2];
  logic [DATA_W-1:0] m_fl [2];
  logic [IN_W-1:0]   m_fs [2];
  logic [31:0]       m_fc [2];
  logic [IN_W-1:0]   m_hist [$];  // last LAT enabled stimulus words, oldest first
  logic [31:0]       max_err [2] = '{32'd1, 32'd0};

  always @(posedge clk) begin
    logic [IN_W-1:0] aligned;
    logic            mm;
    logic [31:0]     idx;
    aligned = (LAT == 0 || m_hist.size() == 0) ? stim_in : m_hist[0];
    mm      = (o_vhdl !== o_verilog);
    if (rst) begin
      for (int k = 0; k < 2; k++) begin
        m_n[k] = 0; m_err[k] = 0; m_done[k] = 0; m_pass[k] = 0;
        m_fv[k] = 0; m_fl[k] = 0; m_fs[k] = 0; m_fc[k] = 0;
      end
      m_hist = {};
      for (int i = 0; i < int'(LAT); i++) m_hist.push_back('0);
    end else if (en) begin
      for (int k = 0; k < 2; k++) begin
        if (!m_done[k]) begin
          if (m_n[k] < WARMUP) begin
            m_n[k]++;
          end else begin
            idx = m_n[k] - WARMUP;
            if (mm) begin
              if (m_err[k] == 0) begin
                m_fv[k] = o_vhdl; m_fl[k] = o_verilog; m_fs[k] = aligned; m_fc[k] = idx;
              end
              if (m_err[k] < 32'hFFFF) m_err[k]++;
            end
            m_n[k]++;
            if (max_err[k] != 0 && m_err[k] >= max_err[k]) begin
              m_done[k] = 1; m_pass[k] = 0;
            end else if (idx + 1 == RUN_LEN) begin
              m_done[k] = 1; m_pass[k] = (m_err[k] == 0);
            end
          end
        end
      end
      if (LAT > 0) begin
        m_hist.push_back(stim_in);
        void'(m_hist.pop_front());
      end
    end
    #1;
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("dut%0d busy", k), 32'(busy[k]), 32'(!m_done[k]));
      chk($sformatf("dut%0d done", k), 32'(done[k]), 32'(m_done[k]));
      chk($sformatf("dut%0d pass", k), 32'(pass[k]), 32'(m_pass[k]));
      chk($sformatf("dut%0d err_cnt", k), 32'(err_cnt[k]), m_err[k]);
      chk($sformatf("dut%0d fail_vhdl", k), 32'(fail_vhdl[k]), 32'(m_fv[k]));
      chk($sformatf("dut%0d fail_verilog", k), 32'(fail_verilog[k]), 32'(m_fl[k]));
      chk($sformatf("dut%0d fail_stim", k), 32'(fail_stim[k]), 32'(m_fs[k]));
      chk($sformatf("dut%0d fail_cycle", k), fail_cycle[k], m_fc[k]);
    end
  end

  // ---------------- stimulus ----------------
  // Each step presents one input set and returns on the following falling edge.
  task automatic step(input logic [IN_W-1:0] s, input logic [DATA_W-1:0] a,
                      input logic [DATA_W-1:0] b, input logic e);
    en = e; stim_in = s; o_vhdl = a; o_verilog = b;
    @(negedge clk);
  endtask

  task automatic rcyc(input logic mm, input logic e);
    logic [DATA_W-1:0] v;
    logic [DATA_W-1:0] flip;
    v    = DATA_W'($urandom);
    flip = DATA_W'(1) << $urandom_range(DATA_W - 1, 0);
    step(IN_W'($urandom), v, mm ? (v ^ flip) : v, e);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    rcyc(1'b1, 1'b1);
    rst = 1'b0;
  endtask

  initial begin
    @(negedge clk);
    rst = 1'b0;

    // Identical outputs: verdict exactly WARMUP+RUN_LEN enabled cycles after reset.
    do_reset();
    for (int i = 0; i < 110; i++) begin
      step(IN_W'($urandom), 16'h0003, 16'h0003, 1'b1);
      if (i == 108) chk("s1 done before 110", 32'(done[0]), 32'd0);
    end
    chk("s1 done", 32'(done[0]), 32'd1);
    chk("s1 pass", 32'(pass[0]), 32'd1);
    chk("s1 err_cnt", 32'(err_cnt[1]), 32'd0);

    // Single mismatch at compare cycle 5, stimulus 6 presented the cycle before.
    do_reset();
    for (int i = 0; i < 110; i++) begin
      if (i == int'(WARMUP) + 4) step(4'h6, 16'h1234, 16'h1234, 1'b1);
      else if (i == int'(WARMUP) + 5) step(4'hA, 16'h0007, 16'h0006, 1'b1);
      else rcyc(1'b0, 1'b1);
      if (i == int'(WARMUP) + 4) chk("s2 done before", 32'(done[0]), 32'd0);
      if (i == int'(WARMUP) + 5) begin
        chk("s2 done", 32'(done[0]), 32'd1);
        chk("s2 pass", 32'(pass[0]), 32'd0);
        chk("s2 err_cnt", 32'(err_cnt[0]), 32'd1);
        chk("s2 fail_vhdl", 32'(fail_vhdl[0]), 32'h7);
        chk("s2 fail_verilog", 32'(fail_verilog[0]), 32'h6);
        chk("s2 fail_stim", 32'(fail_stim[0]), 32'h6);
        chk("s2 fail_cycle", fail_cycle[0], 32'd5);
      end
    end
    chk("s2 run-to-end fail", 32'(done[1] && !pass[1]), 32'd1);

    // Mismatches during warm-up only are ignored.
    do_reset();
    for (int i = 0; i < 110; i++) rcyc(i < int'(WARMUP), 1'b1);
    chk("s3 pass stop", 32'(pass[0]), 32'd1);
    chk("s3 pass run", 32'(pass[1]), 32'd1);
    chk("s3 err_cnt", 32'(err_cnt[0]), 32'd0);

    // MAX_ERR=0 with mismatches at compare cycles 2, 40 and the last one (99).
    do_reset();
    for (int i = 0; i < 110; i++) begin
      int c;
      c = i - int'(WARMUP);
      rcyc(c == 2 || c == 40 || c == 99, 1'b1);
      if (i == 108) chk("s4 done before end", 32'(done[1]), 32'd0);
    end
    chk("s4 done", 32'(done[1]), 32'd1);
    chk("s4 pass", 32'(pass[1]), 32'd0);
    chk("s4 err_cnt", 32'(err_cnt[1]), 32'd3);
    chk("s4 fail_cycle", fail_cycle[1], 32'd2);

    // Reset pulse in the middle of a failing run, then a clean rerun.
    do_reset();
    for (int i = 0; i < int'(WARMUP) + 50; i++) rcyc(i == int'(WARMUP) + 3, 1'b1);
    do_reset();
    chk("s5 busy", 32'(busy[1]), 32'd1);
    chk("s5 done", 32'(done[0]), 32'd0);
    chk("s5 err_cnt", 32'(err_cnt[1]), 32'd0);
    chk("s5 fail_cycle", fail_cycle[1], 32'd0);
    for (int i = 0; i < 110; i++) rcyc(1'b0, 1'b1);
    chk("s5 rerun pass", 32'(pass[1]), 32'd1);

    // en low for 20 cycles inside CHECK delays the verdict by exactly 20 cycles.
    do_reset();
    for (int i = 0; i < 130; i++) begin
      rcyc(1'b0, !(i >= 40 && i < 60));
      if (i == 128) chk("s6 done before 130", 32'(done[0]), 32'd0);
    end
    chk("s6 pass", 32'(pass[0]), 32'd1);

    // Random traffic: sparse mismatches, random enable gaps, rare resets.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(499, 0) == 0);
      rcyc($urandom_range(99, 0) < 2, $urandom_range(9, 0) != 0);
    end
    rst = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
